// File: rtl/i2c_xfer_sequencer.sv
// Purpose : round-robin register-access sequencer feeding an I2C master's cmd/wr/rd stream ports.
// Latency : a grant in IDLE is followed by CMD_W on the next cycle; one response per granted request.
// Backpress: every master handshake stalls in place with its fields held; rsp_valid is held until rsp_ready.
//
// Ports:
//   clk, rst                      clock and synchronous active-high reset
//   req_valid/ready/rnw           per-client request handshake and direction (1 = read)
//   req_dev_addr/reg_addr/wdata   packed per-client fields (7, 8 and 8 bits per client)
//   rsp_valid/ready/id/rdata/err  single response channel (id = client index, err = NACK or timeout)
//   cmd_*                         command stream to the I2C master
//   wr_*                          write-data stream to the I2C master
//   rd_*                          read-data stream from the I2C master
//   missed_ack, busy              master NACK pulse and master busy status
//
// Optional feature: define I2C_SEQ_TIMEOUT_EN to add a per-transaction watchdog of TIMEOUT_CYCLES.
module i2c_xfer_sequencer #(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ-1:0]     req_rnw,
    input  logic [7*NUM_REQ-1:0]   req_dev_addr,
    input  logic [8*NUM_REQ-1:0]   req_reg_addr,
    input  logic [8*NUM_REQ-1:0]   req_wdata,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [2:0]             rsp_id,
    output logic [7:0]             rsp_rdata,
    output logic                   rsp_err,
    output logic [6:0]             cmd_address,
    output logic                   cmd_start,
    output logic                   cmd_read,
    output logic                   cmd_write,
    output logic                   cmd_write_multiple,
    output logic                   cmd_stop,
    output logic                   cmd_valid,
    input  logic                   cmd_ready,
    output logic [7:0]             wr_data,
    output logic                   wr_valid,
    output logic                   wr_last,
    input  logic                   wr_ready,
    input  logic [7:0]             rd_data,
    input  logic                   rd_valid,
    output logic                   rd_ready,
    input  logic                   missed_ack,
    input  logic                   busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD_W,
        S_DAT_REG,
        S_DAT_WD,
        S_CMD_R,
        S_RD,
        S_WAIT_IDLE,
        S_RSP
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Captured request
    logic       r_rnw;
    logic [6:0] r_dev;
    logic [7:0] r_reg;
    logic [7:0] r_wdata;
    logic [2:0] r_id;
    logic [2:0] r_rr_ptr;
    logic       r_err;
    logic [7:0] r_rdata;
    logic       r_armed;     // set once WAIT_IDLE has been occupied for a full cycle

    // Arbitration
    logic               w_any;
    logic [2:0]         w_gnt;
    logic [3:0]         w_cand;
    logic [NUM_REQ-1:0] w_vld_shift;
    logic [NUM_REQ-1:0] w_rnw_shift;
    logic [NUM_REQ-1:0] w_gnt_onehot;
    logic               w_grant;

    // Handshakes
    logic w_cmd_st;
    logic w_wr_st;
    logic w_cmd_hs;
    logic w_wr_hs;
    logic w_rd_hs;
    logic w_active;
    logic w_timeout;

    // Search order starts one past the last winner and wraps, so every client
    // gets a turn before any client is served twice.
    always_comb begin
        w_any       = 1'b0;
        w_gnt       = r_rr_ptr;
        w_cand      = '0;
        w_vld_shift = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            w_cand = 4'(int'(r_rr_ptr) + i);
            if (w_cand >= 4'(NUM_REQ)) begin
                w_cand = w_cand - 4'(NUM_REQ);
            end
            w_vld_shift = req_valid >> w_cand;
            if (!w_any && w_vld_shift[0]) begin
                w_any = 1'b1;
                w_gnt = w_cand[2:0];
            end
        end
    end

    assign w_rnw_shift  = req_rnw >> w_gnt;
    assign w_gnt_onehot = NUM_REQ'(1) << w_gnt;
    assign w_grant      = (r_state == S_IDLE) && w_any && !rst;

    assign w_active = (r_state != S_IDLE) && (r_state != S_RSP);
    assign w_cmd_st = (r_state == S_CMD_W) || (r_state == S_CMD_R);
    assign w_wr_st  = (r_state == S_DAT_REG) || (r_state == S_DAT_WD);
    assign w_cmd_hs = w_cmd_st && !w_timeout && cmd_ready;
    assign w_wr_hs  = w_wr_st && !w_timeout && wr_ready;
    assign w_rd_hs  = (r_state == S_RD) && !w_timeout && rd_valid;

`ifdef I2C_SEQ_TIMEOUT_EN
    logic [15:0] r_wdog;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wdog <= '0;
        end else if (!w_active) begin
            r_wdog <= '0;
        end else if (!w_timeout) begin
            r_wdog <= r_wdog + 16'd1;
        end
    end

    assign w_timeout = w_active && (r_wdog >= 16'(TIMEOUT_CYCLES));
`else
    // No watchdog: the comparison is never true but keeps the parameter referenced.
    assign w_timeout = (TIMEOUT_CYCLES < 0);
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and outputs. Field outputs come from captured registers so
    // they cannot move while a valid is stalled.
    always_comb begin
        w_state_nxt        = r_state;
        req_ready          = '0;
        cmd_valid          = 1'b0;
        cmd_address        = '0;
        cmd_start          = 1'b0;
        cmd_read           = 1'b0;
        cmd_write          = 1'b0;
        cmd_write_multiple = 1'b0;
        cmd_stop           = 1'b0;
        wr_valid           = 1'b0;
        wr_data            = '0;
        wr_last            = 1'b0;
        rd_ready           = 1'b0;
        rsp_valid          = 1'b0;
        rsp_id             = '0;
        rsp_rdata          = '0;
        rsp_err            = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_grant) begin
                    req_ready   = w_gnt_onehot;
                    w_state_nxt = S_CMD_W;
                end
            end
            S_CMD_W: begin
                // Write phase of both transaction types; a read keeps the bus
                // (no stop) so the following read issues a repeated start.
                cmd_valid          = !w_timeout;
                cmd_address        = r_dev;
                cmd_start          = 1'b1;
                cmd_write_multiple = 1'b1;
                cmd_stop           = !r_rnw;
                if (w_cmd_hs) begin
                    w_state_nxt = S_DAT_REG;
                end
            end
            S_DAT_REG: begin
                wr_valid = !w_timeout;
                wr_data  = r_reg;
                wr_last  = r_rnw;
                if (w_wr_hs) begin
                    w_state_nxt = r_rnw ? S_CMD_R : S_DAT_WD;
                end
            end
            S_DAT_WD: begin
                wr_valid = !w_timeout;
                wr_data  = r_wdata;
                wr_last  = 1'b1;
                if (w_wr_hs) begin
                    w_state_nxt = S_WAIT_IDLE;
                end
            end
            S_CMD_R: begin
                cmd_valid   = !w_timeout;
                cmd_address = r_dev;
                cmd_start   = 1'b1;
                cmd_read    = 1'b1;
                cmd_stop    = 1'b1;
                // A NACK here means the master aborts and no read data will follow.
                if (missed_ack) begin
                    w_state_nxt = S_WAIT_IDLE;
                end else if (w_cmd_hs) begin
                    w_state_nxt = S_RD;
                end
            end
            S_RD: begin
                rd_ready = !w_timeout;
                if (missed_ack || w_rd_hs) begin
                    w_state_nxt = S_WAIT_IDLE;
                end
            end
            S_WAIT_IDLE: begin
                // busy may lag the last handshake by a cycle, so it is not
                // trusted on the entry cycle.
                if (r_armed && !busy) begin
                    w_state_nxt = S_RSP;
                end
            end
            S_RSP: begin
                rsp_valid = 1'b1;
                rsp_id    = r_id;
                rsp_rdata = r_rdata;
                rsp_err   = r_err;
                if (rsp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if (w_timeout) begin
            w_state_nxt = S_RSP;
        end
    end

    // Request capture, error flag and read data
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rnw    <= 1'b0;
            r_dev    <= '0;
            r_reg    <= '0;
            r_wdata  <= '0;
            r_id     <= '0;
            r_rr_ptr <= 3'(NUM_REQ - 1);
            r_err    <= 1'b0;
            r_rdata  <= '0;
            r_armed  <= 1'b0;
        end else begin
            r_armed <= (r_state == S_WAIT_IDLE);
            if (w_grant) begin
                r_rnw    <= w_rnw_shift[0];
                r_dev    <= 7'(req_dev_addr >> (7 * w_gnt));
                r_reg    <= 8'(req_reg_addr >> (8 * w_gnt));
                r_wdata  <= 8'(req_wdata >> (8 * w_gnt));
                r_id     <= w_gnt;
                r_rr_ptr <= w_gnt;
                r_err    <= 1'b0;
                r_rdata  <= '0;
            end else begin
                if (missed_ack && w_active) begin
                    r_err <= 1'b1;
                end
                // Data arriving alongside a NACK is not trusted; rdata stays 0.
                if (w_rd_hs && !missed_ack) begin
                    r_rdata <= rd_data;
                end
                if (w_timeout) begin
                    r_err   <= 1'b1;
                    r_rdata <= '0;
                end
            end
        end
    end

endmodule
